algo_2r2w_b752_rdwr_path: RTL and testbench

Port-side datapath for the 2R2W b752 memory. Sits between the two read and two write client ports and the physical t1 memory ports: A/B for writes, C/D for reads. It carries out these functions:
- optional input flopping;
- same-address dual-write arbitration;
- parity generation and checking;
- read-return tracking across the T1_DELAY memory latency;
- the flopout_en-gated output register that drives rd_dout/rd_vld.

---
 rtl/algo_2r2w_b752_pkg.sv | 10 +
 rtl/algo_2r2w_b752_rdtrack.sv | 63 ++++++
 rtl/algo_2r2w_b752_rdwr_path.sv | 129 ++++++++++++
 tb/tb_algo_2r2w_b752_rdwr_path.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/algo_2r2w_b752_pkg.sv
// algo_2r2w_b752_pkg: shared port counts, counter width and parity helper
package algo_2r2w_b752_pkg;
    localparam int NUMRDPRT = 2;
    localparam int NUMWRPRT = 2;
    localparam int PERRW    = 16;

    function automatic logic par_calc(input logic [63:0] word);
        return ^word;
    endfunction
endpackage

// File: rtl/algo_2r2w_b752_rdtrack.sv
// algo_2r2w_b752_rdtrack: per-port read-return tracking, parity check and optional output register
module algo_2r2w_b752_rdtrack
    import algo_2r2w_b752_pkg::*;
#(
    parameter int WIDTH     = 15,
    parameter int T1_DELAY  = 2,
    parameter int FLOPOUT   = 0,
    parameter int IP_ENAPAR = 0,
    parameter int MWIDTH    = WIDTH + IP_ENAPAR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flopoutEn,
    input  logic              issue,
    input  logic [MWIDTH-1:0] memDout,
    output logic [WIDTH-1:0]  rdDout,
    output logic              rdVld,
    output logic              rdPerr,
    output logic              perrEvt
);
    logic [T1_DELAY-1:0] vldPipe;
    logic                tail;
    logic                bad;
    logic [WIDTH-1:0]    retData;

    assign tail    = vldPipe[T1_DELAY-1];
    assign bad     = (IP_ENAPAR != 0) && tail && par_calc(64'(memDout));
    assign retData = tail ? memDout[WIDTH-1:0] : '0;

    // one bit per issued read; the tail bit is set in the cycle its data sits on memDout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vldPipe <= '0;
        else      vldPipe <= (vldPipe << 1) | T1_DELAY'(issue);
    end

    generate
        if (FLOPOUT != 0) begin : genFlopOut
            // output register loads only on flopoutEn; perrEvt pulses once per newly loaded error
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdVld   <= 1'b0;
                    rdDout  <= '0;
                    rdPerr  <= 1'b0;
                    perrEvt <= 1'b0;
                end else begin
                    perrEvt <= flopoutEn && bad;
                    if (flopoutEn) begin
                        rdVld  <= tail;
                        rdDout <= retData;
                        rdPerr <= bad;
                    end
                end
            end
        end else begin : genPassOut
            logic unused;
            assign unused  = flopoutEn;
            assign rdVld   = tail;
            assign rdDout  = retData;
            assign rdPerr  = bad;
            assign perrEvt = bad;
        end
    endgenerate
endmodule

// File: rtl/algo_2r2w_b752_rdwr_path.sv
// algo_2r2w_b752_rdwr_path: client-to-t1 port datapath with write arbitration, parity and read tracking
module algo_2r2w_b752_rdwr_path
    import algo_2r2w_b752_pkg::*;
#(
    parameter int WIDTH     = 15,
    parameter int BITADDR   = 8,
    parameter int T1_DELAY  = 2,
    parameter int FLOPIN    = 0,
    parameter int FLOPOUT   = 0,
    parameter int IP_ENAPAR = 0,
    parameter int MWIDTH    = WIDTH + IP_ENAPAR
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flopout_en,
    input  logic [NUMRDPRT-1:0]         read,
    input  logic [NUMRDPRT*BITADDR-1:0] rd_adr,
    input  logic [NUMWRPRT-1:0]         write,
    input  logic [NUMWRPRT*BITADDR-1:0] wr_adr,
    input  logic [NUMWRPRT*WIDTH-1:0]   din,
    input  logic [NUMWRPRT*WIDTH-1:0]   bw,
    output logic [NUMRDPRT*WIDTH-1:0]   rd_dout,
    output logic [NUMRDPRT-1:0]         rd_vld,
    output logic [NUMRDPRT-1:0]         rd_perr,
    output logic [PERRW-1:0]            perr_cnt,
    output logic                        t1_readC,
    output logic                        t1_readD,
    output logic [BITADDR-1:0]          t1_addrC,
    output logic [BITADDR-1:0]          t1_addrD,
    input  logic [MWIDTH-1:0]           t1_doutC,
    input  logic [MWIDTH-1:0]           t1_doutD,
    output logic                        t1_writeA,
    output logic                        t1_writeB,
    output logic [BITADDR-1:0]          t1_addrA,
    output logic [BITADDR-1:0]          t1_addrB,
    output logic [MWIDTH-1:0]           t1_dinA,
    output logic [MWIDTH-1:0]           t1_dinB,
    output logic [MWIDTH-1:0]           t1_bwA,
    output logic [MWIDTH-1:0]           t1_bwB
);
    localparam int CW = PERRW + 1;

    logic [NUMRDPRT-1:0]         readS;
    logic [NUMWRPRT-1:0]         writeS;
    logic [NUMRDPRT*BITADDR-1:0] rdAdrS;
    logic [NUMWRPRT*BITADDR-1:0] wrAdrS;
    logic [NUMWRPRT*WIDTH-1:0]   dinS;
    logic [NUMWRPRT*WIDTH-1:0]   bwS;
    logic                        sameAdr;
    logic [MWIDTH-1:0]           memDout [NUMRDPRT];
    logic [NUMRDPRT-1:0]         perrEvt;
    logic [CW-1:0]               cntSum;

    generate
        if (FLOPIN != 0) begin : genFlopIn
            // stage client commands one cycle; valids clear on reset so nothing issues from reset state
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    readS  <= '0;
                    writeS <= '0;
                    rdAdrS <= '0;
                    wrAdrS <= '0;
                    dinS   <= '0;
                    bwS    <= '0;
                end else begin
                    readS  <= read;
                    writeS <= write;
                    rdAdrS <= rd_adr;
                    wrAdrS <= wr_adr;
                    dinS   <= din;
                    bwS    <= bw;
                end
            end
        end else begin : genPassIn
            assign readS  = read & {NUMRDPRT{rst}};
            assign writeS = write & {NUMWRPRT{rst}};
            assign rdAdrS = rd_adr;
            assign wrAdrS = wr_adr;
            assign dinS   = din;
            assign bwS    = bw;
        end
    endgenerate

    assign t1_readC = readS[0];
    assign t1_readD = readS[1];
    assign t1_addrC = rdAdrS[BITADDR-1:0];
    assign t1_addrD = rdAdrS[2*BITADDR-1:BITADDR];

    assign sameAdr   = writeS[0] && writeS[1] && (wrAdrS[BITADDR-1:0] == wrAdrS[2*BITADDR-1:BITADDR]);
    assign t1_writeA = writeS[0] && !sameAdr;
    assign t1_writeB = writeS[1];
    assign t1_addrA  = wrAdrS[BITADDR-1:0];
    assign t1_addrB  = wrAdrS[2*BITADDR-1:BITADDR];
    assign t1_dinA   = MWIDTH'({par_calc(64'(dinS[WIDTH-1:0])), dinS[WIDTH-1:0]});
    assign t1_dinB   = MWIDTH'({par_calc(64'(dinS[2*WIDTH-1:WIDTH])), dinS[2*WIDTH-1:WIDTH]});
    assign t1_bwA    = MWIDTH'({|bwS[WIDTH-1:0], bwS[WIDTH-1:0]});
    assign t1_bwB    = MWIDTH'({|bwS[2*WIDTH-1:WIDTH], bwS[2*WIDTH-1:WIDTH]});

    assign memDout[0] = t1_doutC;
    assign memDout[1] = t1_doutD;

    for (genvar i = 0; i < NUMRDPRT; i++) begin : genTrack
        algo_2r2w_b752_rdtrack #(
            .WIDTH    (WIDTH),
            .T1_DELAY (T1_DELAY),
            .FLOPOUT  (FLOPOUT),
            .IP_ENAPAR(IP_ENAPAR),
            .MWIDTH   (MWIDTH)
        ) uTrack (
            .clk      (clk),
            .rst      (rst),
            .flopoutEn(flopout_en),
            .issue    (readS[i]),
            .memDout  (memDout[i]),
            .rdDout   (rd_dout[i*WIDTH +: WIDTH]),
            .rdVld    (rd_vld[i]),
            .rdPerr   (rd_perr[i]),
            .perrEvt  (perrEvt[i])
        );
    end

    assign cntSum = CW'(perr_cnt) + CW'(perrEvt[0]) + CW'(perrEvt[1]);

    // saturating parity-error count, lagging the rd_perr it counts by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) perr_cnt <= '0;
        else      perr_cnt <= cntSum[PERRW] ? '1 : cntSum[PERRW-1:0];
    end
endmodule

// File: tb/tb_algo_2r2w_b752_rdwr_path.sv
// tb_algo_2r2w_b752_rdwr_path: two configurations driven in lockstep against a client-level memory model
module tb_algo_2r2w_b752_rdwr_path;
    localparam int W = 15;
    localparam int A = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flopoutEn = 1'b1;
    logic [1:0]     read = '0;
    logic [1:0]     write = '0;
    logic [1:0]     inj = '0;
    logic [2*A-1:0] rdAdr = '0;
    logic [2*A-1:0] wrAdr = '0;
    logic [2*W-1:0] din = '0;
    logic [2*W-1:0] bw [2];
    logic [2*W-1:0] rdDout [2];
    logic [1:0]     rdVld [2];
    logic [1:0]     rdPerr [2];
    logic [15:0]    perrCnt [2];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int seen0, seen1, issued;

    logic [W-1:0]   sh [2][256];
    logic           rawV [2][2][64];
    logic           rawP [2][2][64];
    logic [W-1:0]   rawD [2][2][64];
    logic [1:0]     oV, oP;
    logic [2*W-1:0] oD;
    int             cnt [2];
    int             pulse1;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int MW = W + g;
        logic          readC, readD, writeA, writeB;
        logic [A-1:0]  addrA, addrB, addrC, addrD;
        logic [MW-1:0] doutC, doutD, dinA, dinB, bwA, bwB, flipC, flipD;
        logic [MW-1:0] mem [256];
        logic [MW-1:0] pipeC [2];
        logic [MW-1:0] pipeD [2];
        logic [1:0]    injQ = '0;

        algo_2r2w_b752_rdwr_path #(.FLOPIN(g), .FLOPOUT(g), .IP_ENAPAR(g)) dut (
            .clk(clk), .rst(rst), .flopout_en(flopoutEn),
            .read(read), .rd_adr(rdAdr), .write(write), .wr_adr(wrAdr), .din(din), .bw(bw[g]),
            .rd_dout(rdDout[g]), .rd_vld(rdVld[g]), .rd_perr(rdPerr[g]), .perr_cnt(perrCnt[g]),
            .t1_readC(readC), .t1_readD(readD), .t1_addrC(addrC), .t1_addrD(addrD),
            .t1_doutC(doutC), .t1_doutD(doutD),
            .t1_writeA(writeA), .t1_writeB(writeB), .t1_addrA(addrA), .t1_addrB(addrB),
            .t1_dinA(dinA), .t1_dinB(dinB), .t1_bwA(bwA), .t1_bwB(bwB)
        );

        assign doutC = pipeC[1];
        assign doutD = pipeD[1];
        assign flipC = (g == 1 && injQ[0]) ? MW'(8) : '0;
        assign flipD = (g == 1 && injQ[1]) ? MW'(8) : '0;

        initial for (int i = 0; i < 256; i++) mem[i] = '0;

        // physical memory: reads capture pre-write contents, data appears two cycles after issue
        always @(posedge clk) begin
            injQ     <= inj;
            pipeC[0] <= mem[addrC] ^ flipC;
            pipeC[1] <= pipeC[0];
            pipeD[0] <= mem[addrD] ^ flipD;
            pipeD[1] <= pipeD[0];
            if (writeA) mem[addrA] = (mem[addrA] & ~bwA) | (dinA & bwA);
            if (writeB) mem[addrB] = (mem[addrB] & ~bwB) | (dinB & bwB);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return v > 65535 ? 65535 : v;
    endfunction

    task automatic clr();
        for (int g = 0; g < 2; g++) begin
            cnt[g] = 0;
            for (int p = 0; p < 2; p++)
                for (int s = 0; s < 64; s++) begin
                    rawV[g][p][s] = 1'b0;
                    rawP[g][p][s] = 1'b0;
                    rawD[g][p][s] = '0;
                end
        end
        oV = '0; oP = '0; oD = '0; pulse1 = 0;
    endtask

    task automatic tick();
        int s, t, lat;
        logic [1:0] ev, ep, v1, p1;
        logic [2*W-1:0] ed, d1;
        logic [A-1:0] a0, a1;
        @(negedge clk);
        s  = cyc % 64;
        ev = {rawV[0][1][s], rawV[0][0][s]};
        ep = {rawP[0][1][s], rawP[0][0][s]};
        ed = {rawD[0][1][s], rawD[0][0][s]};
        chk("vld0", 64'(rdVld[0]), 64'(ev));
        chk("dout0", 64'(rdDout[0]), 64'(ed));
        chk("perr0", 64'(rdPerr[0]), 64'(ep));
        chk("cnt0", 64'(perrCnt[0]), 64'(cnt[0]));
        chk("vld1", 64'(rdVld[1]), 64'(oV));
        chk("dout1", 64'(rdDout[1]), 64'(oD));
        chk("perr1", 64'(rdPerr[1]), 64'(oP));
        chk("cnt1", 64'(perrCnt[1]), 64'(cnt[1]));
        seen0 += $countones(rdVld[0]);
        seen1 += $countones(rdVld[1]);
        if (rst) begin
            cnt[0] = sat(cnt[0] + $countones(ev & ep));
            cnt[1] = sat(cnt[1] + pulse1);
            v1 = {rawV[1][1][s], rawV[1][0][s]};
            p1 = {rawP[1][1][s], rawP[1][0][s]};
            d1 = {rawD[1][1][s], rawD[1][0][s]};
            pulse1 = flopoutEn ? $countones(v1 & p1) : 0;
            if (flopoutEn) begin
                oV = v1;
                oP = v1 & p1;
                oD = d1;
            end
            for (int g = 0; g < 2; g++) begin
                for (int p = 0; p < 2; p++) begin
                    rawV[g][p][s] = 1'b0;
                    rawP[g][p][s] = 1'b0;
                    rawD[g][p][s] = '0;
                end
                lat = 2 + g;
                t = (cyc + lat) % 64;
                for (int p = 0; p < 2; p++)
                    if (read[p]) begin
                        rawV[g][p][t] = 1'b1;
                        rawP[g][p][t] = (g == 1) && inj[p];
                        rawD[g][p][t] = sh[g][rdAdr[p*A +: A]] ^ (((g == 1) && inj[p]) ? 15'h8 : 15'h0);
                    end
                a0 = wrAdr[A-1:0];
                a1 = wrAdr[2*A-1:A];
                if (write[0] && !(write[1] && a0 == a1))
                    sh[g][a0] = (sh[g][a0] & ~bw[g][W-1:0]) | (din[W-1:0] & bw[g][W-1:0]);
                if (write[1])
                    sh[g][a1] = (sh[g][a1] & ~bw[g][2*W-1:W]) | (din[2*W-1:W] & bw[g][2*W-1:W]);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic waitTo(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        int t;
        logic b0, b1;
        bw[0] = '0;
        bw[1] = '0;
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 256; i++) sh[g][i] = '0;
        clr();
        #1 rst = 1'b0;
        repeat (3) tick();
        chk("rstEn0", 64'({u[0].readC, u[0].readD, u[0].writeA, u[0].writeB}), 64'(0));
        chk("rstEn1", 64'({u[1].readC, u[1].readD, u[1].writeA, u[1].writeB}), 64'(0));
        rst = 1'b1;
        tick();

        write = 2'b01; wrAdr = {8'd0, 8'd5}; din = {15'h0, 15'h1234};
        bw[0] = {2{15'h7fff}}; bw[1] = {2{15'h7fff}};
        #1;
        chk("wrEn0", 64'({u[0].writeA, u[0].writeB}), 64'(2'b10));
        chk("dinA0", 64'(u[0].dinA), 64'(15'h1234));
        tick();
        chk("wrEn1", 64'({u[1].writeA, u[1].writeB}), 64'(2'b10));
        chk("dinA1", 64'(u[1].dinA), 64'(16'h9234));
        chk("bwA1", 64'(u[1].bwA), 64'(16'hffff));
        write = 2'b00; read = 2'b10; rdAdr = {8'd5, 8'd0};
        t = cyc;
        tick();
        read = 2'b00;
        waitTo(t + 2);
        chk("basicVld0", 64'(rdVld[0]), 64'(2'b10));
        chk("basicDat0", 64'(rdDout[0][2*W-1:W]), 64'(15'h1234));
        waitTo(t + 4);
        chk("basicVld1", 64'(rdVld[1]), 64'(2'b10));
        chk("basicDat1", 64'(rdDout[1][2*W-1:W]), 64'(15'h1234));
        tick();

        write = 2'b11; wrAdr = {8'd7, 8'd7}; din = {15'h0555, 15'h0aaa};
        #1;
        chk("dualEn0", 64'({u[0].writeA, u[0].writeB}), 64'(2'b01));
        chk("dualDin0", 64'(u[0].dinB), 64'(15'h0555));
        tick();
        chk("dualEn1", 64'({u[1].writeA, u[1].writeB}), 64'(2'b01));
        chk("dualDin1", 64'(u[1].dinB), 64'(16'h0555));
        chk("dualBw1", 64'(u[1].bwB), 64'(16'hffff));
        write = 2'b00; read = 2'b01; rdAdr = {8'd0, 8'd7};
        t = cyc;
        tick();
        read = 2'b00;
        waitTo(t + 2);
        chk("dualRd0", 64'(rdDout[0][W-1:0]), 64'(15'h0555));
        waitTo(t + 4);
        chk("dualRd1", 64'(rdDout[1][W-1:0]), 64'(15'h0555));
        tick();

        read = 2'b01; rdAdr = {8'd0, 8'd5}; inj = 2'b01;
        t = cyc;
        tick();
        read = 2'b00; inj = 2'b00;
        waitTo(t + 4);
        chk("perrHit", 64'(rdPerr[1]), 64'(2'b01));
        chk("perrDat", 64'(rdDout[1][W-1:0]), 64'(15'h123c));
        waitTo(t + 5);
        chk("perrCnt1", 64'(perrCnt[1]), 64'(1));
        chk("perrOnce", 64'(rdPerr[1]), 64'(0));

        read = 2'b01; rdAdr = {8'd0, 8'd5};
        t = cyc;
        tick();
        read = 2'b00;
        waitTo(t + 4);
        chk("gateVld", 64'(rdVld[1]), 64'(2'b01));
        flopoutEn = 1'b0;
        repeat (3) tick();
        chk("holdVld", 64'(rdVld[1]), 64'(2'b01));
        chk("holdDat", 64'(rdDout[1][W-1:0]), 64'(15'h1234));
        flopoutEn = 1'b1;
        repeat (2) tick();

        read = 2'b11; inj = 2'b11;
        for (int i = 0; i < 32780; i++) begin
            rdAdr = 16'($urandom);
            tick();
        end
        read = 2'b00; inj = 2'b00;
        repeat (6) tick();
        chk("satCnt1", 64'(perrCnt[1]), 64'(16'hffff));
        chk("satCnt0", 64'(perrCnt[0]), 64'(0));

        read = 2'b11; write = 2'b11; rdAdr = {8'd3, 8'd4}; wrAdr = {8'd9, 8'd10};
        repeat (2) tick();
        rst = 1'b0;
        #1;
        clr();
        chk("rstVld", 64'({rdVld[0], rdVld[1]}), 64'(0));
        chk("rstDat", 64'({rdDout[0], rdDout[1]}), 64'(0));
        chk("rstPerr", 64'({rdPerr[0], rdPerr[1]}), 64'(0));
        chk("rstCnt", 64'({perrCnt[0], perrCnt[1]}), 64'(0));
        chk("rstT1g0", 64'({u[0].readC, u[0].readD, u[0].writeA, u[0].writeB}), 64'(0));
        chk("rstT1g1", 64'({u[1].readC, u[1].readD, u[1].writeA, u[1].writeB}), 64'(0));
        repeat (2) tick();
        read = 2'b00; write = 2'b00;
        rst = 1'b1;
        repeat (6) tick();

        seen0 = 0; seen1 = 0; issued = 0;
        for (int i = 0; i < 120; i++) begin
            read  = 2'($urandom);
            write = 2'($urandom);
            rdAdr = {4'h0, 4'($urandom), 4'h0, 4'($urandom)};
            wrAdr = {4'h0, 4'($urandom), 4'h0, 4'($urandom)};
            din   = 30'($urandom);
            bw[0] = 30'($urandom);
            b0 = 1'($urandom);
            b1 = 1'($urandom);
            bw[1] = {{W{b1}}, {W{b0}}};
            inj   = read & 2'($urandom);
            issued += $countones(read);
            tick();
        end
        read = 2'b00; write = 2'b00; inj = 2'b00;
        repeat (8) tick();
        chk("vldCount0", 64'(seen0), 64'(issued));
        chk("vldCount1", 64'(seen1), 64'(issued));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
